// File: rtl/sram_oq_write_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_oq_write_scheduler                                                  |
// | Round-robin packet arbiter sharing one SRAM write port across queues.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sram_oq_write_scheduler #(
   parameter int NUM_QUEUES     = 5,
   parameter int QUEUE_ID_WIDTH = 3,
   parameter int MEM_ADDR_WIDTH = 19,
   parameter int MEM_NUM_WORDS  = 524288,
   parameter int QUEUE_SIZE     = MEM_NUM_WORDS / 5,
   parameter int MAX_PKT_WORDS  = 48
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_QUEUES-1:0]     buf_empty,
   input  logic [NUM_QUEUES-1:0]     buf_last,
   output logic [NUM_QUEUES-1:0]     buf_rden,
   input  logic                      mem_ready,
   output logic                      wr_en,
   output logic [MEM_ADDR_WIDTH-1:0] wr_addr,
   output logic [QUEUE_ID_WIDTH-1:0] wr_queue,
   output logic                      wr_last,
   input  logic                      free_en,
   input  logic [QUEUE_ID_WIDTH-1:0] free_queue,
   output logic [NUM_QUEUES-1:0]     queue_full,
   output logic [NUM_QUEUES-1:0]     queue_empty,
   output logic                      free_err
);

   localparam logic [MEM_ADDR_WIDTH-1:0] TAIL_LAST = MEM_ADDR_WIDTH'(QUEUE_SIZE - 1);
   localparam logic [MEM_ADDR_WIDTH-1:0] TAIL_ONE  = MEM_ADDR_WIDTH'(1);
   localparam logic [MEM_ADDR_WIDTH:0]   OCC_ONE   = (MEM_ADDR_WIDTH + 1)'(1);
   localparam logic [MEM_ADDR_WIDTH:0]   FULL_THR  = (MEM_ADDR_WIDTH + 1)'(QUEUE_SIZE - MAX_PKT_WORDS);

   typedef enum logic [0:0] {IDLE = 1'b0, XFER = 1'b1} state_t;

   state_t                    state, state_nx;
   logic [QUEUE_ID_WIDTH-1:0] grant, grant_nx;
   logic [QUEUE_ID_WIDTH-1:0] last_grant, last_grant_nx;
   logic [QUEUE_ID_WIDTH-1:0] cand;
   logic [MEM_ADDR_WIDTH-1:0] tail [NUM_QUEUES];
   logic [MEM_ADDR_WIDTH-1:0] base [NUM_QUEUES];
   logic [MEM_ADDR_WIDTH:0]   occ [NUM_QUEUES];
   logic [MEM_ADDR_WIDTH:0]   occ_nx [NUM_QUEUES];
   logic [MEM_ADDR_WIDTH-1:0] sel_base, sel_tail;
   logic [NUM_QUEUES-1:0]     elig;
   logic                      xfer, found, any_free, free_err_nx;
   int                        idx;

   // Region bases are constants, so the address path is a mux plus one adder.
   genvar gq;
   generate
      for (gq = 0; gq < NUM_QUEUES; gq++) begin : g_base
         assign base[gq] = MEM_ADDR_WIDTH'(gq * QUEUE_SIZE);
      end
   endgenerate

   assign elig = ~buf_empty & ~queue_full;

   always_comb begin
      sel_base = '0;
      sel_tail = '0;
      for (int q = 0; q < NUM_QUEUES; q++) begin
         if (grant == QUEUE_ID_WIDTH'(q)) begin
            sel_base = base[q];
            sel_tail = tail[q];
         end
      end
   end

   always_comb begin
      state_nx      = state;
      grant_nx      = grant;
      last_grant_nx = last_grant;
      xfer          = 1'b0;
      buf_rden      = '0;
      wr_en         = 1'b0;
      wr_addr       = '0;
      wr_queue      = '0;
      wr_last       = 1'b0;
      found         = 1'b0;
      idx           = 0;
      cand          = '0;
      case (state)
         IDLE: begin
            for (int i = 1; i <= NUM_QUEUES; i++) begin
               idx = int'(last_grant) + i;
               if (idx >= NUM_QUEUES) idx = idx - NUM_QUEUES;
               cand = QUEUE_ID_WIDTH'(idx);
               if (!found && elig[cand]) begin
                  found    = 1'b1;
                  grant_nx = cand;
                  state_nx = XFER;
               end
            end
         end
         XFER: begin
            if (!buf_empty[grant] && mem_ready) begin
               xfer            = 1'b1;
               buf_rden[grant] = 1'b1;
               wr_en           = 1'b1;
               wr_addr         = sel_base + sel_tail;
               wr_queue        = grant;
               wr_last         = buf_last[grant];
               if (buf_last[grant]) begin
                  state_nx      = IDLE;
                  last_grant_nx = grant;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // A write and a valid free to the same queue cancel out.
   always_comb begin
      any_free = 1'b0;
      for (int q = 0; q < NUM_QUEUES; q++) begin
         logic inc, dec;
         inc = xfer && (grant == QUEUE_ID_WIDTH'(q));
         dec = free_en && (free_queue == QUEUE_ID_WIDTH'(q)) && (occ[q] != '0);
         any_free = any_free | dec;
         occ_nx[q] = occ[q];
         if (inc && !dec) occ_nx[q] = occ[q] + OCC_ONE;
         else if (dec && !inc) occ_nx[q] = occ[q] - OCC_ONE;
      end
      free_err_nx = free_en && !any_free;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         grant       <= '0;
         last_grant  <= QUEUE_ID_WIDTH'(NUM_QUEUES - 1);
         queue_full  <= '0;
         queue_empty <= '1;
         free_err    <= 1'b0;
         for (int q = 0; q < NUM_QUEUES; q++) begin
            tail[q] <= '0;
            occ[q]  <= '0;
         end
      end else begin
         state      <= state_nx;
         grant      <= grant_nx;
         last_grant <= last_grant_nx;
         free_err   <= free_err_nx;
         for (int q = 0; q < NUM_QUEUES; q++) begin
            if (xfer && (grant == QUEUE_ID_WIDTH'(q)))
               tail[q] <= (tail[q] == TAIL_LAST) ? '0 : tail[q] + TAIL_ONE;
            occ[q]         <= occ_nx[q];
            queue_full[q]  <= occ_nx[q] > FULL_THR;
            queue_empty[q] <= occ_nx[q] == '0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sram_oq_write_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sram_oq_write_scheduler                                               |
// | Randomised bench with a queue-level reference model of the scheduler.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sram_oq_write_scheduler;

   localparam int NQ   = 5;
   localparam int QW   = 3;
   localparam int AW   = 19;
   localparam int QS   = 64;
   localparam int MAXP = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [NQ-1:0] buf_empty, buf_last, buf_rden;
   logic          mem_ready;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [QW-1:0] wr_queue;
   logic          wr_last;
   logic          free_en;
   logic [QW-1:0] free_queue;
   logic [NQ-1:0] queue_full, queue_empty;
   logic          free_err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   bit            bq [NQ][$];
   logic [NQ-1:0] hold;
   logic [NQ-1:0] pop_mask;
   int            m_occ [NQ];
   int            m_tail [NQ];
   int            m_owner;
   int            m_last;
   bit            err_prev;
   bit            mon_en;

   typedef struct {int q; int addr; bit last; int cyc;} wr_t;
   wr_t log_q[$];

   sram_oq_write_scheduler #(
      .NUM_QUEUES(NQ), .QUEUE_ID_WIDTH(QW), .MEM_ADDR_WIDTH(AW),
      .MEM_NUM_WORDS(524288), .QUEUE_SIZE(QS), .MAX_PKT_WORDS(MAXP)
   ) dut (
      .clk(clk), .reset(reset), .buf_empty(buf_empty), .buf_last(buf_last),
      .buf_rden(buf_rden), .mem_ready(mem_ready), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_queue(wr_queue), .wr_last(wr_last), .free_en(free_en), .free_queue(free_queue),
      .queue_full(queue_full), .queue_empty(queue_empty), .free_err(free_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic refresh();
      for (int q = 0; q < NQ; q++) begin
         buf_empty[q] = (bq[q].size() == 0) || hold[q];
         buf_last[q]  = (bq[q].size() != 0) ? bq[q][0] : 1'b0;
      end
   endtask

   // FIFO model: pops observed in the previous cycle take effect just after the edge.
   always @(posedge clk) begin
      #1;
      for (int q = 0; q < NQ; q++)
         if (pop_mask[q] && bq[q].size() != 0) void'(bq[q].pop_front());
      pop_mask = '0;
      refresh();
   end

   // Reference model + scoreboard, evaluated mid-cycle.
   always @(negedge clk) begin : mon
      int wq, fq;
      bit this_err, found, inc, exp_x;
      int cand;
      logic [AW-1:0] ea;
      pop_mask = buf_rden;
      if (mon_en) begin
         total++;
         if (free_err !== err_prev) begin
            bad++; $display("FAIL free_err: got %b want %b (cyc %0d)", free_err, err_prev, cyc);
         end
         for (int q = 0; q < NQ; q++) begin
            total++;
            if (queue_empty[q] !== (m_occ[q] == 0) || queue_full[q] !== (m_occ[q] > QS - MAXP)) begin
               bad++; $display("FAIL flags q%0d: got empty=%b full=%b occ_model=%0d", q, queue_empty[q], queue_full[q], m_occ[q]);
            end
         end
         this_err = 0; inc = 0; wq = 0;
         if (m_owner < 0) begin
            total++;
            if (wr_en !== 1'b0 || buf_rden !== '0) begin
               bad++; $display("FAIL idle_strobe: got wr_en=%b rden=%b want 0", wr_en, buf_rden);
            end
            found = 0;
            for (int i = 1; i <= NQ; i++) begin
               cand = (m_last + i) % NQ;
               if (!found && !buf_empty[cand] && !(m_occ[cand] > QS - MAXP)) begin
                  found = 1; m_owner = cand;
               end
            end
         end else begin
            wq = m_owner;
            exp_x = !buf_empty[wq] && mem_ready;
            total++;
            if (wr_en !== exp_x) begin
               bad++; $display("FAIL wr_en q%0d: got %b want %b", wq, wr_en, exp_x);
            end
            if (exp_x && wr_en === 1'b1) begin
               ea = AW'(wq * QS + m_tail[wq]);
               total++;
               if (wr_addr !== ea || wr_queue !== QW'(wq) || wr_last !== bq[wq][0] ||
                   buf_rden !== (NQ'(1) << wq)) begin
                  bad++;
                  $display("FAIL write: got addr=%0d q=%0d last=%b rden=%b want addr=%0d q=%0d last=%b",
                           wr_addr, wr_queue, wr_last, buf_rden, ea, wq, bq[wq][0]);
               end
               log_q.push_back('{wq, wq * QS + m_tail[wq], bq[wq][0], cyc});
               m_tail[wq] = (m_tail[wq] + 1) % QS;
               inc = 1;
               if (bq[wq][0]) begin m_last = wq; m_owner = -1; end
            end else begin
               total++;
               if (buf_rden !== '0) begin
                  bad++; $display("FAIL stall_rden: got %b want 0", buf_rden);
               end
            end
         end
         if (free_en) begin
            fq = int'(free_queue);
            if (fq >= NQ) this_err = 1;
            else if (m_occ[fq] == 0) this_err = 1;
            else m_occ[fq]--;
         end
         if (inc) m_occ[wq]++;
         err_prev = this_err;
      end
   end

   task automatic step();
      @(posedge clk); #2;
   endtask

   task automatic push_pkt(input int q, input int len);
      for (int i = 0; i < len; i++) bq[q].push_back(i == len - 1);
      refresh();
   endtask

   task automatic do_free(input int q);
      free_en = 1'b1; free_queue = QW'(q);
      step();
      free_en = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      bit busy = 1;
      while (busy && n < budget) begin
         step(); n++;
         busy = (m_owner >= 0);
         for (int q = 0; q < NQ; q++) if (bq[q].size() != 0) busy = 1;
      end
      total++;
      if (busy) begin bad++; $display("FAIL wait_idle: still busy after %0d cycles, want idle", n); end
   endtask

   task automatic do_reset();
      mon_en = 0; reset = 1'b1; free_en = 1'b0; mem_ready = 1'b1; hold = '0;
      for (int q = 0; q < NQ; q++) bq[q].delete();
      refresh();
      step(); step();
      for (int q = 0; q < NQ; q++) begin m_occ[q] = 0; m_tail[q] = 0; end
      m_owner = -1; m_last = NQ - 1; err_prev = 0;
      log_q.delete();
      reset = 1'b0; mon_en = 1;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      total++;
      if (buf_rden !== '0 || wr_en !== 1'b0 || wr_addr !== '0 || wr_queue !== '0 || wr_last !== 1'b0) begin
         bad++; $display("FAIL reset_outputs: got rden=%b wr_en=%b addr=%0d q=%0d last=%b want all 0",
                         buf_rden, wr_en, wr_addr, wr_queue, wr_last);
      end
      total++;
      if (queue_full !== 5'b00000 || queue_empty !== 5'b11111 || free_err !== 1'b0) begin
         bad++; $display("FAIL reset_flags: got full=%b empty=%b err=%b want 00000 11111 0", queue_full, queue_empty, free_err);
      end
      step();
   endtask

   task automatic test_single();
      int c;
      do_reset();
      push_pkt(2, 3);
      c = cyc;
      wait_idle(20);
      total++;
      if (log_q.size() != 3) begin bad++; $display("FAIL single_count: got %0d want 3", log_q.size()); end
      else for (int i = 0; i < 3; i++) begin
         total++;
         if (log_q[i].addr != 2 * QS + i || log_q[i].cyc != c + 1 + i || log_q[i].last != (i == 2)) begin
            bad++; $display("FAIL single_word%0d: got addr=%0d cyc=%0d last=%b want addr=%0d cyc=%0d last=%b",
                            i, log_q[i].addr, log_q[i].cyc, log_q[i].last, 2 * QS + i, c + 1 + i, i == 2);
         end
      end
      @(negedge clk);
      total++;
      if (queue_empty[2] !== 1'b0) begin bad++; $display("FAIL single_empty: got %b want 0", queue_empty[2]); end
      step();
   endtask

   task automatic test_round_robin();
      int exp_q [6] = '{0, 1, 4, 0, 1, 4};
      do_reset();
      for (int r = 0; r < 2; r++) begin push_pkt(0, 1); push_pkt(1, 1); push_pkt(4, 1); end
      wait_idle(40);
      total++;
      if (log_q.size() != 6) begin bad++; $display("FAIL rr_count: got %0d want 6", log_q.size()); end
      else for (int i = 0; i < 6; i++) begin
         total++;
         if (log_q[i].q != exp_q[i]) begin
            bad++; $display("FAIL rr_order%0d: got q%0d want q%0d", i, log_q[i].q, exp_q[i]);
         end
      end
   endtask

   task automatic test_wrap();
      int remaining = 60;
      int len;
      do_reset();
      while (remaining > 0) begin
         len = $urandom_range(1, MAXP);
         if (len > remaining) len = remaining;
         push_pkt(1, len);
         wait_idle(40);
         for (int j = 0; j < len; j++) do_free(1);
         remaining -= len;
      end
      log_q.delete();
      push_pkt(1, 6);
      wait_idle(40);
      total++;
      if (log_q.size() != 6) begin bad++; $display("FAIL wrap_count: got %0d want 6", log_q.size()); end
      else for (int i = 0; i < 6; i++) begin
         total++;
         if (log_q[i].addr != QS + (60 + i) % QS) begin
            bad++; $display("FAIL wrap_addr%0d: got %0d want %0d", i, log_q[i].addr, QS + (60 + i) % QS);
         end
      end
   endtask

   task automatic test_full();
      do_reset();
      for (int p = 0; p < 7; p++) push_pkt(3, 8);
      push_pkt(3, 1);
      wait_idle(200);
      @(negedge clk);
      total++;
      if (queue_full[3] !== 1'b1 || queue_full[0] !== 1'b0) begin
         bad++; $display("FAIL full_set: got full=%b want q3=1 q0=0", queue_full);
      end
      step();
      log_q.delete();
      push_pkt(3, 1);
      push_pkt(0, 2);
      for (int i = 0; i < 10; i++) step();
      total++;
      if (log_q.size() != 2 || log_q[0].q != 0 || log_q[1].q != 0 || bq[3].size() != 1) begin
         bad++; $display("FAIL full_skip: got writes=%0d q3_pending=%0d want 2 writes to q0 and q3 pending 1",
                         log_q.size(), bq[3].size());
      end
      do_free(3);
      @(negedge clk);
      total++;
      if (queue_full[3] !== 1'b0) begin bad++; $display("FAIL full_clear: got %b want 0", queue_full[3]); end
      step();
      wait_idle(20);
      total++;
      if (log_q.size() != 3 || log_q[log_q.size()-1].q != 3 || log_q[log_q.size()-1].addr != 3 * QS + 57) begin
         bad++; $display("FAIL full_regrant: got writes=%0d want 3 with last at addr %0d", log_q.size(), 3 * QS + 57);
      end
   endtask

   task automatic test_stall();
      int n = 0;
      do_reset();
      push_pkt(4, 8);
      while (log_q.size() < 3 && n < 50) begin step(); n++; end
      hold[4] = 1'b1; refresh();
      total++;
      if (log_q.size() != 3) begin bad++; $display("FAIL stall_setup: got %0d writes want 3", log_q.size()); end
      push_pkt(0, 1);
      for (int i = 0; i < 6; i++) begin
         if (i == 4) begin hold[4] = 1'b0; mem_ready = 1'b0; refresh(); end
         @(negedge clk);
         total++;
         if (wr_en !== 1'b0 || buf_rden !== '0) begin
            bad++; $display("FAIL stall_cycle%0d: got wr_en=%b rden=%b want 0", i, wr_en, buf_rden);
         end
         step();
      end
      mem_ready = 1'b1;
      wait_idle(40);
      total++;
      if (log_q.size() != 9) begin bad++; $display("FAIL stall_count: got %0d want 9", log_q.size()); end
      else for (int i = 0; i < 9; i++) begin
         total++;
         if ((i < 8 && log_q[i].addr != 4 * QS + i) || (i == 8 && log_q[i].addr != 0)) begin
            bad++; $display("FAIL stall_addr%0d: got %0d want %0d", i, log_q[i].addr, (i < 8) ? 4 * QS + i : 0);
         end
      end
   endtask

   task automatic test_free_err();
      do_reset();
      do_free(0);
      @(negedge clk);
      total++;
      if (free_err !== 1'b1 || queue_empty[0] !== 1'b1) begin
         bad++; $display("FAIL err_empty: got err=%b empty0=%b want 1 1", free_err, queue_empty[0]);
      end
      step();
      @(negedge clk);
      total++;
      if (free_err !== 1'b0) begin bad++; $display("FAIL err_pulse: got %b want 0", free_err); end
      step();
      do_free(6);
      @(negedge clk);
      total++;
      if (free_err !== 1'b1) begin bad++; $display("FAIL err_range: got %b want 1", free_err); end
      step();
      push_pkt(2, 5);
      wait_idle(30);
      push_pkt(2, 1);
      step();
      free_en = 1'b1; free_queue = 3'd2;
      @(negedge clk);
      total++;
      if (wr_en !== 1'b1 || wr_queue !== 3'd2) begin
         bad++; $display("FAIL simul_write: got wr_en=%b q=%0d want 1 2", wr_en, wr_queue);
      end
      step();
      free_en = 1'b0;
      for (int i = 0; i < 4; i++) do_free(2);
      @(negedge clk);
      total++;
      if (queue_empty[2] !== 1'b0) begin bad++; $display("FAIL simul_occ4: got empty=%b want 0", queue_empty[2]); end
      step();
      do_free(2);
      @(negedge clk);
      total++;
      if (queue_empty[2] !== 1'b1 || free_err !== 1'b0) begin
         bad++; $display("FAIL simul_occ5: got empty=%b err=%b want 1 0", queue_empty[2], free_err);
      end
      step();
      do_free(2);
      @(negedge clk);
      total++;
      if (free_err !== 1'b1) begin bad++; $display("FAIL simul_over: got %b want 1", free_err); end
      step();
   endtask

   task automatic test_reset_abort();
      int n = 0;
      do_reset();
      push_pkt(1, 8);
      while (log_q.size() < 3 && n < 50) begin step(); n++; end
      do_reset();
      @(negedge clk);
      total++;
      if (wr_en !== 1'b0 || queue_empty !== 5'b11111) begin
         bad++; $display("FAIL abort_state: got wr_en=%b empty=%b want 0 11111", wr_en, queue_empty);
      end
      step();
      push_pkt(1, 2);
      wait_idle(20);
      total++;
      if (log_q.size() != 2 || log_q[0].addr != QS) begin
         bad++; $display("FAIL abort_tail: got writes=%0d want 2 starting at %0d", log_q.size(), QS);
      end
   endtask

   task automatic test_random();
      int n = 0;
      bit busy = 1;
      int fq;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         for (int q = 0; q < NQ; q++) begin
            if ($urandom_range(0, 5) == 0 && bq[q].size() < 16) push_pkt(q, $urandom_range(1, MAXP));
            hold[q] = ($urandom_range(0, 7) == 0);
         end
         mem_ready = ($urandom_range(0, 3) != 0);
         free_en = ($urandom_range(0, 1) == 1);
         free_queue = ($urandom_range(0, 4) == 0) ? QW'($urandom_range(0, 7)) : QW'($urandom_range(0, NQ - 1));
         refresh();
         step();
      end
      hold = '0; mem_ready = 1'b1; refresh();
      while (busy && n < 4000) begin
         fq = $urandom_range(0, NQ - 1);
         free_en = (m_occ[fq] > 0); free_queue = QW'(fq);
         step(); n++;
         busy = (m_owner >= 0);
         for (int q = 0; q < NQ; q++) if (bq[q].size() != 0) busy = 1;
      end
      free_en = 1'b0;
      total++;
      if (busy) begin bad++; $display("FAIL random_drain: still busy after %0d cycles, want idle", n); end
      step();
   endtask

   initial begin
      reset = 1'b1; free_en = 1'b0; free_queue = '0; mem_ready = 1'b1;
      hold = '0; pop_mask = '0; mon_en = 0; buf_empty = '1; buf_last = '0;
      m_owner = -1; m_last = NQ - 1; err_prev = 0;
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_full();
      test_stall();
      test_free_err();
      test_reset_abort();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
